// File: rtl/pci_target_ctrl.sv
// PCI target controller: claims memory read/write cycles aimed at a 16-byte
// window at DEV_BASE and serves them from four 32-bit registers. Bursts walk
// the registers in order, wrapping from reg[3] back to reg[0].
module pci_target_ctrl #(
  parameter logic [31:0] DEV_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [31:0] AD_in,
  input  logic [3:0]  CBE,
  output logic [31:0] AD_out,
  output logic        AD_oe,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic        data_c,
  output logic [2:0]  xfer_cnt
);

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    DATA,
    TURN,
    BUSY
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] regs [4];
  logic [1:0]  idx;
  logic [1:0]  idx_inc;
  logic [3:0]  cmd;

  logic        addr_hit;
  logic        abandon;
  logic        complete;
  logic        is_read;

  // Address decode, bus qualifiers and the next register index.
  always_comb begin
    addr_hit = (AD_in[31:4] == DEV_BASE[31:4]) &&
               ((CBE == CMD_MEM_READ) || (CBE == CMD_MEM_WRITE));
    // Master gave up: neither a frame nor a ready data phase is pending.
    abandon  = FRAME && IRDY;
    complete = (state == DATA) && !IRDY;
    is_read  = (cmd == CMD_MEM_READ);
    idx_inc  = idx + 2'd1;
  end

  // Next-state decode for the bus protocol FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the case statement can leave it unassigned and infer a latch.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!FRAME) begin
          next_state = addr_hit ? CLAIM : BUSY;
        end
      end
      CLAIM: begin
        next_state = abandon ? TURN : DATA;
      end
      DATA: begin
        if (complete) begin
          next_state = FRAME ? TURN : DATA;
        end else if (abandon) begin
          next_state = TURN;
        end
      end
      TURN: begin
        next_state = IDLE;
      end
      BUSY: begin
        if (abandon) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register; reset wins over any bus activity in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus handshake outputs, registered from the state being entered so they
  // line up with the state register rather than trailing it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      DEVSEL <= 1'b1;
      TRDY   <= 1'b1;
      AD_oe  <= 1'b0;
      data_c <= 1'b0;
    end else begin
      DEVSEL <= !((next_state == CLAIM) || (next_state == DATA));
      TRDY   <= !(next_state == DATA);
      // cmd is already latched whenever DATA is being entered.
      AD_oe  <= (next_state == DATA) && is_read;
      data_c <= (next_state == CLAIM);
    end
  end

  // Address-phase capture, data-phase index and completed-phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 2'd0;
      cmd      <= 4'd0;
      xfer_cnt <= 3'd0;
    end else begin
      if ((state == IDLE) && !FRAME) begin
        idx <= AD_in[3:2];
        cmd <= CBE;
      end else if (complete) begin
        idx <= idx_inc;
      end

      if ((state == IDLE) && (next_state == CLAIM)) begin
        xfer_cnt <= 3'd0;
      end else if (complete && (xfer_cnt != 3'd7)) begin
        xfer_cnt <= xfer_cnt + 3'd1;
      end
    end
  end

  // Read data: prefetch the addressed register as DATA is entered, then the
  // following register after each completed phase; holds over wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      AD_out <= 32'd0;
    end else if (is_read) begin
      if ((state == CLAIM) && (next_state == DATA)) begin
        AD_out <= regs[idx];
      end else if (complete) begin
        AD_out <= regs[idx_inc];
      end
    end
  end

  // Register file with per-byte write enables (CBE is active low).
  always_ff @(posedge clk) begin
    // NOTE: this small register file is reset because software must read
    // zeros after reset; larger memories would normally be left unreset.
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        regs[r] <= 32'd0;
      end
    end else if (complete && (cmd == CMD_MEM_WRITE)) begin
      for (int b = 0; b < 4; b++) begin
        if (!CBE[b]) begin
          regs[idx][8*b +: 8] <= AD_in[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Self-checking bench for pci_target_ctrl: a table of single-phase
// transactions plus hand-written bursts, abandons and a mid-burst reset.
// Expected read data is queued when a read is issued and popped as each
// data phase completes.
module tb_pci_target_ctrl;

  localparam logic [3:0] RD  = 4'b0110;
  localparam logic [3:0] WR  = 4'b0111;
  localparam logic [3:0] IOR = 4'b0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        FRAME;
  logic        IRDY;
  logic [31:0] AD_in;
  logic [3:0]  CBE;
  logic [31:0] AD_out;
  logic        AD_oe;
  logic        DEVSEL;
  logic        TRDY;
  logic        data_c;
  logic [2:0]  xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  pci_target_ctrl #(.DEV_BASE(32'h0000_1000)) dut (
    .clk      (clk),
    .rst      (rst),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .AD_in    (AD_in),
    .CBE      (CBE),
    .AD_out   (AD_out),
    .AD_oe    (AD_oe),
    .DEVSEL   (DEVSEL),
    .TRDY     (TRDY),
    .data_c   (data_c),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_read(input string name);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h with no queued expectation", name, AD_out);
    end else begin
      exp = sb_q.pop_front();
      check(name, AD_out, exp);
    end
  endtask

  task automatic idle_bus();
    FRAME = 1'b1;
    IRDY  = 1'b1;
    AD_in = 32'd0;
    CBE   = 4'd0;
  endtask

  // One transaction of n data phases; wait_phase < 0 means no wait state.
  task automatic bus_txn(input string name, input logic [3:0] cmd, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input int n,
                         input int wait_phase, input logic exp_hit);
    logic [31:0] held;
    logic        is_rd;
    int          exp_cnt;
    is_rd   = (cmd == RD);
    exp_cnt = (n > 7) ? 7 : n;
    FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; CBE = cmd;
    tick();
    if (!exp_hit) begin
      FRAME = 1'b0; IRDY = 1'b0; AD_in = wdata; CBE = be;
      for (int c = 0; c < 3; c++) begin
        if (c == 2) FRAME = 1'b1;
        tick();
        check({name, " miss DEVSEL"}, 32'(DEVSEL), 32'd1);
        check({name, " miss TRDY"},   32'(TRDY),   32'd1);
        check({name, " miss data_c"}, 32'(data_c), 32'd0);
        check({name, " miss AD_oe"},  32'(AD_oe),  32'd0);
      end
      idle_bus();
      tick();
      return;
    end
    check({name, " claim data_c"},   32'(data_c),   32'd1);
    check({name, " claim DEVSEL"},   32'(DEVSEL),   32'd0);
    check({name, " claim TRDY"},     32'(TRDY),     32'd1);
    check({name, " claim AD_oe"},    32'(AD_oe),    32'd0);
    check({name, " claim xfer_cnt"}, 32'(xfer_cnt), 32'd0);
    FRAME = (n == 1); IRDY = 1'b0; AD_in = wdata; CBE = be;
    tick();
    check({name, " data data_c"}, 32'(data_c), 32'd0);
    check({name, " data DEVSEL"}, 32'(DEVSEL), 32'd0);
    check({name, " data TRDY"},   32'(TRDY),   32'd0);
    check({name, " data AD_oe"},  32'(AD_oe),  32'(is_rd));
    for (int p = 0; p < n; p++) begin
      if (p == wait_phase) begin
        FRAME = 1'b0; IRDY = 1'b1;
        held = AD_out;
        tick();
        check({name, " wait AD_out hold"}, AD_out, held);
        check({name, " wait TRDY"}, 32'(TRDY), 32'd0);
      end
      FRAME = (p == n - 1); IRDY = 1'b0; AD_in = wdata + 32'(p); CBE = be;
      if (is_rd) check_read({name, " rdata"});
      tick();
    end
    check({name, " turn DEVSEL"},   32'(DEVSEL),   32'd1);
    check({name, " turn TRDY"},     32'(TRDY),     32'd1);
    check({name, " turn AD_oe"},    32'(AD_oe),    32'd0);
    check({name, " turn xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    idle_bus();
    tick();
    check({name, " idle DEVSEL"},   32'(DEVSEL),   32'd1);
    check({name, " idle data_c"},   32'(data_c),   32'd0);
    check({name, " idle xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  task automatic read_one(input string name, input logic [31:0] addr, input logic [31:0] exp);
    sb_q.push_back(exp);
    bus_txn(name, RD, addr, 4'd0, 32'd0, 1, -1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"rst_rd0",  RD,  32'h0000_1000, 4'h0, 32'h0,          1'b1, 32'h0000_0000};
    vecs[1]  = '{"rst_rd1",  RD,  32'h0000_1004, 4'h0, 32'h0,          1'b1, 32'h0000_0000};
    vecs[2]  = '{"rst_rd2",  RD,  32'h0000_1008, 4'h0, 32'h0,          1'b1, 32'h0000_0000};
    vecs[3]  = '{"rst_rd3",  RD,  32'h0000_100C, 4'h0, 32'h0,          1'b1, 32'h0000_0000};
    vecs[4]  = '{"wr2",      WR,  32'h0000_1008, 4'h0, 32'hDEAD_BEEF,  1'b1, 32'h0};
    vecs[5]  = '{"rd2",      RD,  32'h0000_1008, 4'h0, 32'h0,          1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{"wr0",      WR,  32'h0000_1000, 4'h0, 32'h1122_3344,  1'b1, 32'h0};
    vecs[7]  = '{"wr0_be",   WR,  32'h0000_1000, 4'hE, 32'h0000_00AA,  1'b1, 32'h0};
    vecs[8]  = '{"rd0_be",   RD,  32'h0000_1000, 4'h0, 32'h0,          1'b1, 32'h1122_33AA};
    vecs[9]  = '{"wr1",      WR,  32'h0000_1004, 4'h0, 32'hAABB_CCDD,  1'b1, 32'h0};
    vecs[10] = '{"wr3",      WR,  32'h0000_100C, 4'h0, 32'h5566_7788,  1'b1, 32'h0};
    vecs[11] = '{"wr1_be",   WR,  32'h0000_1004, 4'h5, 32'h1234_5678,  1'b1, 32'h0};
    vecs[12] = '{"rd1_be",   RD,  32'h0000_1004, 4'h0, 32'h0,          1'b1, 32'h12BB_56DD};
    vecs[13] = '{"miss_wr",  WR,  32'h0000_2008, 4'h0, 32'h0000_1008,  1'b0, 32'h0};
    vecs[14] = '{"miss_io",  IOR, 32'h0000_100C, 4'h0, 32'h0,          1'b0, 32'h0};
    vecs[15] = '{"rd2_post", RD,  32'h0000_1008, 4'h0, 32'h0,          1'b1, 32'hDEAD_BEEF};

    // Reset for two cycles while a hit address phase is on the bus.
    rst = 1'b1; FRAME = 1'b0; IRDY = 1'b0; AD_in = 32'h0000_1000; CBE = RD;
    tick();
    tick();
    check("reset DEVSEL",   32'(DEVSEL),   32'd1);
    check("reset TRDY",     32'(TRDY),     32'd1);
    check("reset AD_oe",    32'(AD_oe),    32'd0);
    check("reset data_c",   32'(data_c),   32'd0);
    check("reset xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("reset AD_out",   AD_out,        32'd0);
    idle_bus();
    rst = 1'b0;
    tick();
    check("post reset data_c", 32'(data_c), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].exp_hit && (vecs[i].cmd == RD)) sb_q.push_back(vecs[i].exp_rd);
      bus_txn(vecs[i].name, vecs[i].cmd, vecs[i].addr, vecs[i].be, vecs[i].wdata, 1, -1,
              vecs[i].exp_hit);
    end
    // Registers now: reg0=112233AA reg1=12BB56DD reg2=DEADBEEF reg3=55667788.

    // Burst read from reg3 with a wait state on the second phase.
    sb_q.push_back(32'h5566_7788);
    sb_q.push_back(32'h1122_33AA);
    sb_q.push_back(32'h12BB_56DD);
    sb_q.push_back(32'hDEAD_BEEF);
    bus_txn("burst_rd4", RD, 32'h0000_100C, 4'h0, 32'h0, 4, 1, 1'b1);

    // Eight-phase burst from reg1: wraps twice, counter saturates at 7.
    for (int k = 0; k < 8; k++) begin
      case ((k + 1) % 4)
        0: sb_q.push_back(32'h1122_33AA);
        1: sb_q.push_back(32'h12BB_56DD);
        2: sb_q.push_back(32'hDEAD_BEEF);
        default: sb_q.push_back(32'h5566_7788);
      endcase
    end
    bus_txn("burst_rd8", RD, 32'h0000_1004, 4'h0, 32'h0, 8, -1, 1'b1);

    // Master abandon during CLAIM: no update, count cleared by the claim.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1004; CBE = WR;
    tick();
    check("abort_claim data_c", 32'(data_c), 32'd1);
    FRAME = 1'b1; IRDY = 1'b1; AD_in = 32'hFFFF_FFFF; CBE = 4'h0;
    tick();
    check("abort_claim DEVSEL",   32'(DEVSEL),   32'd1);
    check("abort_claim TRDY",     32'(TRDY),     32'd1);
    check("abort_claim xfer_cnt", 32'(xfer_cnt), 32'd0);
    tick();
    read_one("abort_claim rd1", 32'h0000_1004, 32'h12BB_56DD);

    // Master abandon during DATA.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1008; CBE = WR;
    tick();
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_0000; CBE = 4'h0;
    tick();
    check("abort_data TRDY in DATA", 32'(TRDY), 32'd0);
    FRAME = 1'b1; IRDY = 1'b1;
    tick();
    check("abort_data DEVSEL",   32'(DEVSEL),   32'd1);
    check("abort_data TRDY",     32'(TRDY),     32'd1);
    check("abort_data xfer_cnt", 32'(xfer_cnt), 32'd0);
    tick();
    read_one("abort_data rd2", 32'h0000_1008, 32'hDEAD_BEEF);

    // Reset during the second data phase of a write burst.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1000; CBE = WR;
    tick();
    FRAME = 1'b0; IRDY = 1'b0; AD_in = 32'h0BAD_F00D; CBE = 4'h0;
    tick();
    tick();
    check("midrst first phase xfer_cnt", 32'(xfer_cnt), 32'd1);
    rst = 1'b1; AD_in = 32'h1234_5678;
    tick();
    check("midrst DEVSEL",   32'(DEVSEL),   32'd1);
    check("midrst TRDY",     32'(TRDY),     32'd1);
    check("midrst AD_oe",    32'(AD_oe),    32'd0);
    check("midrst data_c",   32'(data_c),   32'd0);
    check("midrst xfer_cnt", 32'(xfer_cnt), 32'd0);
    rst = 1'b0;
    idle_bus();
    tick();
    read_one("midrst rd0", 32'h0000_1000, 32'h0);
    read_one("midrst rd1", 32'h0000_1004, 32'h0);
    read_one("midrst rd2", 32'h0000_1008, 32'h0);
    read_one("midrst rd3", 32'h0000_100C, 32'h0);
    bus_txn("post_rst wr3", WR, 32'h0000_100C, 4'h0, 32'hCAFE_F00D, 1, -1, 1'b1);
    read_one("post_rst rd3", 32'h0000_100C, 32'hCAFE_F00D);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
